// File: rtl/bounce_gen_if.sv
// Command/status bundle for bounce_gen: start/level request in, emulated raw signal and status out.
interface bounce_gen_if;
    logic       start;
    logic       level;
    logic       bounce_out;
    logic       busy;
    logic       done;
    logic [4:0] glitch_cnt;

    modport master (output start, level, input bounce_out, busy, done, glitch_cnt);
    modport slave  (input start, level, output bounce_out, busy, done, glitch_cnt);
endinterface

// File: rtl/bounce_gen.sv
// Pushbutton bounce emulator: drives a bouncing transition then holds the settled level.
// Define BOUNCE_GEN_LFSR_EN for pseudo-random glitch count/widths; otherwise fixed pattern.
//
// state  | meaning
// IDLE   | holding last settled level, waiting for start
// ON     | output driven to target for one phase
// OFF    | output driven back to old level for one phase
// SETTLE | target held for SETTLE_CYCLES
// DONE   | one-cycle completion, done pulse follows
module bounce_gen #(
    parameter int          MAX_GLITCHES  = 8,
    parameter int          MIN_W         = 3,
    parameter int          W_SPAN        = 16,
    parameter int          SETTLE_CYCLES = 50000,
    parameter logic        RESET_LEVEL   = 1'b0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic         clk,
    input logic         rst_n,
    bounce_gen_if.slave b_if
);
    localparam int PH_MAX  = MIN_W + W_SPAN - 1;
    localparam int CNT_MAX = (PH_MAX > SETTLE_CYCLES) ? PH_MAX : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_SETTLE, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_target, r_old;
    logic [4:0]    r_n, r_gcnt;
    logic [CW-1:0] r_wcnt;
    logic          r_bounce, r_busy, r_done;

    logic [CW-1:0] w_phase_load;
    logic [4:0]    w_n_draw;
    logic          w_tc, w_accept, w_load_phase, w_load_settle, w_glitch_inc;
    logic          w_bounce_nxt, w_busy_nxt, w_done_nxt;

    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("bounce_gen: LFSR_SEED must be non-zero");
    end

`ifdef BOUNCE_GEN_LFSR_EN
    localparam logic [7:0] W_MASK = 8'(W_SPAN - 1);
    localparam logic [3:0] N_MASK = 4'(MAX_GLITCHES - 1);

    logic [15:0] r_lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, free-running in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign w_phase_load = CW'(MIN_W - 1) + CW'(r_lfsr[7:0] & W_MASK);
    assign w_n_draw     = 5'd1 + {1'b0, r_lfsr[3:0] & N_MASK};
`else
    assign w_phase_load = CW'(MIN_W - 1);
    assign w_n_draw     = 5'(MAX_GLITCHES);
`endif

    assign w_tc = (r_wcnt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_load_phase  = 1'b0;
        w_load_settle = 1'b0;
        w_glitch_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_done high means DONE just finished; a start in that cycle is dropped
                if (b_if.start && !r_done) begin
                    w_accept = 1'b1;
                    if (b_if.level != r_bounce) begin
                        w_state_nxt  = S_ON;
                        w_load_phase = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ON: begin
                if (w_tc) begin
                    w_state_nxt  = S_OFF;
                    w_load_phase = 1'b1;
                    w_glitch_inc = 1'b1;
                end
            end
            S_OFF: begin
                if (w_tc) begin
                    if (r_gcnt == r_n) begin
                        w_state_nxt   = S_SETTLE;
                        w_load_settle = 1'b1;
                    end else begin
                        w_state_nxt  = S_ON;
                        w_load_phase = 1'b1;
                    end
                end
            end
            S_SETTLE: if (w_tc) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they lag the state by one edge
    always_comb begin
        w_bounce_nxt = r_bounce;
        case (r_state)
            S_ON, S_SETTLE, S_DONE: w_bounce_nxt = r_target;
            S_OFF:                  w_bounce_nxt = r_old;
            default:                w_bounce_nxt = r_bounce;
        endcase
        w_busy_nxt = (r_state == S_ON) || (r_state == S_OFF) || (r_state == S_SETTLE);
        w_done_nxt = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_target <= RESET_LEVEL;
            r_old    <= RESET_LEVEL;
            r_n      <= '0;
            r_gcnt   <= '0;
            r_wcnt   <= '0;
            r_bounce <= RESET_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bounce <= w_bounce_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;

            if (w_accept) begin
                r_target <= b_if.level;
                r_old    <= r_bounce;
                r_gcnt   <= '0;
                r_n      <= (b_if.level != r_bounce) ? w_n_draw : 5'd0;
            end else if (w_glitch_inc) begin
                r_gcnt <= r_gcnt + 5'd1;
            end

            if (w_load_phase)       r_wcnt <= w_phase_load;
            else if (w_load_settle) r_wcnt <= CW'(SETTLE_CYCLES - 1);
            else if (!w_tc)         r_wcnt <= r_wcnt - 1'b1;
        end
    end

    assign b_if.bounce_out = r_bounce;
    assign b_if.busy       = r_busy;
    assign b_if.done       = r_done;
    assign b_if.glitch_cnt = r_gcnt;
endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: fixed-pattern vectors by default, random-mode bounds with BOUNCE_GEN_LFSR_EN.
module tb_bounce_gen;
`ifdef BOUNCE_GEN_LFSR_EN
    localparam int MG = 8, MW = 3, WS = 16, ST = 20;
`else
    localparam int MG = 4, MW = 3, WS = 16, ST = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bounce_gen_if bif ();

    bounce_gen #(
        .MAX_GLITCHES (MG),
        .MIN_W        (MW),
        .W_SPAN       (WS),
        .SETTLE_CYCLES(ST),
        .RESET_LEVEL  (1'b0),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .b_if (bif)
    );

    typedef struct {
        int   run;
        int   cyc;
        logic eb;
        logic ebusy;
        logic edone;
    } vec_t;

    vec_t        vt[$];
    logic [47:0] tr_b    [3];
    logic [47:0] tr_busy [3];
    logic [47:0] tr_done [3];
    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int r, input int c, input logic b, input logic bz, input logic d);
        vec_t v;
        v.run = r; v.cyc = c; v.eb = b; v.ebusy = bz; v.edone = d;
        vt.push_back(v);
    endtask

    // cycle 0 is the sample just after the edge that accepts start
    task automatic trace(input int run, input logic lvl);
        bif.start = 1'b1;
        bif.level = lvl;
        tick();
        bif.start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            if (k > 0) tick();
            tr_b[run][k]    = bif.bounce_out;
            tr_busy[run][k] = bif.busy;
            tr_done[run][k] = bif.done;
        end
    endtask

    initial begin
        int rise, fall, done_cyc, done_cnt, busy_seen;
        bif.start = 1'b0;
        bif.level = 1'b0;
        #12;
        chk("reset_bounce", int'(bif.bounce_out), 0);
        chk("reset_busy",   int'(bif.busy), 0);
        chk("reset_done",   int'(bif.done), 0);
        chk("reset_glitch", int'(bif.glitch_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

`ifdef BOUNCE_GEN_LFSR_EN
        for (int t = 0; t < 20; t++) begin
            logic tgt, prv;
            int ec[$];
            logic et[$];
            int done_k, gc, ok;
            tgt = (t % 2 == 0);
            bif.start = 1'b1;
            bif.level = tgt;
            tick();
            bif.start = 1'b0;
            prv = bif.bounce_out;
            done_k = -1;
            for (int k = 1; k <= 400 && done_k < 0; k++) begin
                tick();
                if (bif.bounce_out != prv) begin
                    ec.push_back(k);
                    et.push_back(bif.bounce_out == tgt);
                    prv = bif.bounce_out;
                end
                if (bif.done) done_k = k;
            end
            chk($sformatf("rnd%0d_done_seen", t), int'(done_k > 0), 1);
            gc = int'(bif.glitch_cnt);
            chk($sformatf("rnd%0d_glitch_range", t), int'(gc >= 1 && gc <= MG), 1);
            rise = 0; fall = 0;
            foreach (et[i]) if (et[i]) rise++; else fall++;
            chk($sformatf("rnd%0d_toward_edges", t), rise, gc + 1);
            chk($sformatf("rnd%0d_back_edges", t), fall, gc);
            chk($sformatf("rnd%0d_final_level", t), int'(prv), int'(tgt));
            chk($sformatf("rnd%0d_first_edge", t), (ec.size() > 0) ? ec[0] : -1, 1);
            ok = 1;
            for (int i = 0; i + 1 < ec.size(); i++)
                if ((ec[i+1] - ec[i]) < MW || (ec[i+1] - ec[i]) > MW + WS - 1) ok = 0;
            chk($sformatf("rnd%0d_widths", t), ok, 1);
            chk($sformatf("rnd%0d_settle", t), (ec.size() > 0) ? done_k - ec[ec.size()-1] : -1, ST);
            tick();
        end
`else
        add(0, 0, 1'b0, 1'b0, 1'b0); add(0, 1, 1'b1, 1'b1, 1'b0); add(0, 3, 1'b1, 1'b1, 1'b0);
        add(0, 4, 1'b0, 1'b1, 1'b0); add(0, 7, 1'b1, 1'b1, 1'b0); add(0, 12, 1'b0, 1'b1, 1'b0);
        add(0, 22, 1'b0, 1'b1, 1'b0); add(0, 24, 1'b0, 1'b1, 1'b0); add(0, 25, 1'b1, 1'b1, 1'b0);
        add(0, 34, 1'b1, 1'b1, 1'b0); add(0, 35, 1'b1, 1'b0, 1'b1); add(0, 36, 1'b1, 1'b0, 1'b0);
        add(1, 0, 1'b1, 1'b0, 1'b0); add(1, 1, 1'b0, 1'b1, 1'b0); add(1, 3, 1'b0, 1'b1, 1'b0);
        add(1, 4, 1'b1, 1'b1, 1'b0); add(1, 21, 1'b0, 1'b1, 1'b0); add(1, 24, 1'b1, 1'b1, 1'b0);
        add(1, 25, 1'b0, 1'b1, 1'b0); add(1, 35, 1'b0, 1'b0, 1'b1); add(1, 36, 1'b0, 1'b0, 1'b0);
        add(2, 0, 1'b0, 1'b0, 1'b0); add(2, 1, 1'b0, 1'b0, 1'b1); add(2, 2, 1'b0, 1'b0, 1'b0);

        trace(0, 1'b1);
        chk("run0_glitch_cnt", int'(bif.glitch_cnt), 4);
        trace(1, 1'b0);
        chk("run1_glitch_cnt", int'(bif.glitch_cnt), 4);
        trace(2, 1'b0);
        chk("run2_glitch_cnt", int'(bif.glitch_cnt), 0);

        foreach (vt[i]) begin
            chk($sformatf("v%0d_r%0d_c%0d_bounce", i, vt[i].run, vt[i].cyc),
                int'(tr_b[vt[i].run][vt[i].cyc]), int'(vt[i].eb));
            chk($sformatf("v%0d_r%0d_c%0d_busy", i, vt[i].run, vt[i].cyc),
                int'(tr_busy[vt[i].run][vt[i].cyc]), int'(vt[i].ebusy));
            chk($sformatf("v%0d_r%0d_c%0d_done", i, vt[i].run, vt[i].cyc),
                int'(tr_done[vt[i].run][vt[i].cyc]), int'(vt[i].edone));
        end

        for (int r = 0; r < 2; r++) begin
            rise = 0; fall = 0;
            for (int k = 1; k < 48; k++) begin
                if (!tr_b[r][k-1] && tr_b[r][k]) rise++;
                if (tr_b[r][k-1] && !tr_b[r][k]) fall++;
            end
            chk($sformatf("run%0d_rising_edges", r), rise, (r == 0) ? 5 : 4);
            chk($sformatf("run%0d_falling_edges", r), fall, (r == 0) ? 4 : 5);
        end

        // busy rejection at cycle 10, and a start held during the done cycle
        bif.start = 1'b1;
        bif.level = 1'b1;
        tick();
        bif.start = 1'b0;
        done_cyc = -1;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bif.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k == 10 || k == 35) begin
                bif.start = 1'b1;
                bif.level = 1'b0;
            end else begin
                bif.start = 1'b0;
            end
        end
        chk("rej_done_cycle", done_cyc, 35);
        chk("rej_done_count", done_cnt, 1);
        chk("rej_final_bounce", int'(bif.bounce_out), 1);
        chk("rej_final_busy", int'(bif.busy), 0);

        // reset mid-way through a 1->0 transition (output is on its old level at cycle 12)
        bif.start = 1'b1;
        bif.level = 1'b0;
        tick();
        bif.start = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        chk("abort_pre_busy", int'(bif.busy), 1);
        chk("abort_pre_bounce", int'(bif.bounce_out), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_bounce", int'(bif.bounce_out), 0);
        chk("abort_busy", int'(bif.busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bif.done) done_cnt++;
            if (bif.busy) busy_seen++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_busy", busy_seen, 0);
        chk("abort_idle_bounce", int'(bif.bounce_out), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
